// File: rtl/irq4_aggregator_v_pkg.sv
// Shared types and constants for the four-source event aggregator.
// The FSM encoding is 2 bits wide and matches the consumer's debug decoders.
package irq4_aggregator_v_pkg;

    localparam int ID_W  = 2;
    localparam int N_SRC = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

endpackage

// File: rtl/irq4_aggregator_v_if.sv
// Event/request bundle between the event sources, the aggregator and its consumer.
// Handshake: o_irq is valid and i_ack is ready; a request transfers on the edge where both are 1.
import irq4_aggregator_v_pkg::*;

interface irq4_aggregator_v_if #(
    parameter int CNT_W = 4
) ();

    logic             i_a;
    logic             i_b;
    logic             i_c;
    logic             i_d;
    logic [3:0]       i_mask;
    logic             i_ack;
    logic             o_irq;
    logic [ID_W-1:0]  o_id;
    logic [3:0]       o_pend;
    logic [CNT_W-1:0] o_ovf_cnt;
    state_t           dbg_state;

    modport master (
        output i_a, i_b, i_c, i_d, i_mask, i_ack,
        input  o_irq, o_id, o_pend, o_ovf_cnt, dbg_state
    );

    modport slave (
        input  i_a, i_b, i_c, i_d, i_mask, i_ack,
        output o_irq, o_id, o_pend, o_ovf_cnt, dbg_state
    );

endinterface

// File: rtl/irq4_aggregator_v_prio_enc.sv
// Fixed-priority encoder over four requests; bit 0 wins. Valid comes from the shared OR4 cell.
import irq4_aggregator_v_pkg::*;

module irq4_aggregator_v_prio_enc (
    input  logic [N_SRC-1:0] req,
    output logic [ID_W-1:0]  id,
    output logic             valid
);

    or4_gate_v u_or4 (
        .a (req[0]),
        .b (req[1]),
        .c (req[2]),
        .d (req[3]),
        .y (valid)
    );

    always_comb begin
        id = 2'd0;
        if (req[0])      id = 2'd0;
        else if (req[1]) id = 2'd1;
        else if (req[2]) id = 2'd2;
        else if (req[3]) id = 2'd3;
    end

endmodule

// File: rtl/or4_gate_v.sv
// Four-input OR reduction cell.
module or4_gate_v (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic y
);

    assign y = a | b | c | d;

endmodule

// File: rtl/irq4_aggregator_v.sv
// Four-source event aggregator: edge/level capture into sticky pending bits, masking,
// fixed-priority arbitration and a single acked request with a guaranteed idle gap.
import irq4_aggregator_v_pkg::*;

module irq4_aggregator_v #(
    parameter bit EDGE_MODE = 1'b1,
    parameter int CNT_W     = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    irq4_aggregator_v_if.slave  bus
);

    state_t           state_q;
    state_t           state_d;
    logic [ID_W-1:0]  id_q;
    logic [3:0]       prev_q;
    logic [3:0]       pend_q;
    logic [3:0]       pend_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [3:0]       in_vec;
    logic [3:0]       evt;
    logic [3:0]       clr;
    logic [3:0]       ovf;
    logic [3:0]       req;
    logic [ID_W-1:0]  win_id;
    logic             any_req;
    logic             accept;
    logic [2:0]       ovf_n;
    logic [CNT_W+2:0] cnt_sum;

    localparam logic [CNT_W+2:0] CNT_MAX = {3'b000, {CNT_W{1'b1}}};

    assign in_vec = {bus.i_d, bus.i_c, bus.i_b, bus.i_a};
    assign evt    = EDGE_MODE ? (in_vec & ~prev_q) : in_vec;
    assign req    = pend_q & ~bus.i_mask;

    // Ack only counts while the request is actually presented.
    assign accept = (state_q == ST_ASSERT) && bus.i_ack;
    assign clr    = accept ? (4'b0001 << id_q) : 4'b0000;

    // A new event on a bit being cleared re-arms it instead of counting as lost.
    assign pend_d = (pend_q & ~clr) | evt;
    assign ovf    = evt & pend_q & ~clr;

    assign ovf_n   = 3'(ovf[0]) + 3'(ovf[1]) + 3'(ovf[2]) + 3'(ovf[3]);
    assign cnt_sum = {3'b000, cnt_q} + {{CNT_W{1'b0}}, ovf_n};
    assign cnt_d   = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

    irq4_aggregator_v_prio_enc u_prio (
        .req   (req),
        .id    (win_id),
        .valid (any_req)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (any_req) state_d = ST_ASSERT;
            ST_ASSERT: if (bus.i_ack) state_d = ST_GAP;
            ST_GAP:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.o_irq     = (state_q == ST_ASSERT);
        bus.o_id      = id_q;
        bus.o_pend    = pend_q;
        bus.o_ovf_cnt = cnt_q;
        bus.dbg_state = state_q;
    end

    // The id is captured only on entry to ASSERT, so it cannot move under a live request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            id_q   <= '0;
            prev_q <= '0;
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (state_q == ST_IDLE && any_req) begin
                id_q <= win_id;
            end
            prev_q <= in_vec;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_irq4_aggregator_v.sv
// Directed bench for irq4_aggregator_v: per-step expectations are queued, then popped
// and compared against {state, irq, id, pend, ovf_cnt} after each clock edge.
import irq4_aggregator_v_pkg::*;

module tb_irq4_aggregator_v;

    localparam int W = 13;

    logic i_clk;
    logic i_rst;
    int   n_tests;
    int   n_fail;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_vec;

    irq4_aggregator_v_if #(.CNT_W(4)) bus ();

    irq4_aggregator_v #(.EDGE_MODE(1'b1), .CNT_W(4)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    assign obs_vec = {bus.dbg_state, bus.o_irq, bus.o_id, bus.o_pend, bus.o_ovf_cnt};

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue the expected post-edge outputs, clock once, then compare.
    task automatic cyc(input string tag, input logic [1:0] st, input logic irq,
                       input logic [1:0] id, input logic [3:0] pend, input logic [3:0] cnt);
        logic [W-1:0] exp;
        exp_q.push_back({st, irq, id, pend, cnt});
        @(posedge i_clk);
        #1;
        exp = exp_q.pop_front();
        check(tag, 32'(obs_vec), 32'(exp));
    endtask

    initial begin
        logic [1:0] S_I;
        logic [1:0] S_A;
        logic [1:0] S_G;
        logic       seen;
        int         exp_cnt;
        S_I = ST_IDLE;
        S_A = ST_ASSERT;
        S_G = ST_GAP;
        n_tests = 0;
        n_fail  = 0;
        i_rst = 1'b1;
        bus.i_a = 1'b0; bus.i_b = 1'b0; bus.i_c = 1'b0; bus.i_d = 1'b0;
        bus.i_mask = 4'b0000;
        bus.i_ack = 1'b0;

        // T1 reset
        cyc("t1_reset_0", S_I, 1'b0, 2'd0, 4'b0000, 4'd0);
        cyc("t1_reset_1", S_I, 1'b0, 2'd0, 4'b0000, 4'd0);
        i_rst = 1'b0;

        // T2 single event on c
        bus.i_c = 1'b1;
        cyc("t2_pend", S_I, 1'b0, 2'd0, 4'b0100, 4'd0);
        bus.i_c = 1'b0;
        cyc("t2_irq", S_A, 1'b1, 2'd2, 4'b0100, 4'd0);
        bus.i_ack = 1'b1;
        cyc("t2_ack", S_G, 1'b0, 2'd2, 4'b0000, 4'd0);
        bus.i_ack = 1'b0;
        cyc("t2_idle", S_I, 1'b0, 2'd2, 4'b0000, 4'd0);

        // T3 priority, with ack held through GAP/IDLE
        bus.i_b = 1'b1; bus.i_d = 1'b1;
        cyc("t3_pend", S_I, 1'b0, 2'd2, 4'b1010, 4'd0);
        bus.i_b = 1'b0; bus.i_d = 1'b0;
        cyc("t3_first_b", S_A, 1'b1, 2'd1, 4'b1010, 4'd0);
        bus.i_ack = 1'b1;
        cyc("t3_gap", S_G, 1'b0, 2'd1, 4'b1000, 4'd0);
        cyc("t3_idle_held_ack", S_I, 1'b0, 2'd1, 4'b1000, 4'd0);
        cyc("t3_second_d", S_A, 1'b1, 2'd3, 4'b1000, 4'd0);
        cyc("t3_ack_d", S_G, 1'b0, 2'd3, 4'b0000, 4'd0);
        bus.i_ack = 1'b0;
        cyc("t3_idle", S_I, 1'b0, 2'd3, 4'b0000, 4'd0);

        // T4 mask: pending latched but never arbitrated; stray acks ignored
        bus.i_mask = 4'b0001;
        bus.i_a = 1'b1;
        cyc("t4_pend", S_I, 1'b0, 2'd3, 4'b0001, 4'd0);
        bus.i_a = 1'b0;
        bus.i_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc($sformatf("t4_masked_%0d", i), S_I, 1'b0, 2'd3, 4'b0001, 4'd0);
        end
        bus.i_ack = 1'b0;
        bus.i_mask = 4'b0000;
        seen = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            @(posedge i_clk);
            #1;
            if (bus.o_irq === 1'b1) seen = 1'b1;
        end
        check("t4_unmask_irq_within_2", 32'(seen), 32'd1);
        check("t4_unmask_state", 32'(obs_vec), 32'({S_A, 1'b1, 2'd0, 4'b0001, 4'd0}));
        bus.i_ack = 1'b1;
        cyc("t4_ack", S_G, 1'b0, 2'd0, 4'b0000, 4'd0);
        bus.i_ack = 1'b0;
        cyc("t4_idle", S_I, 1'b0, 2'd0, 4'b0000, 4'd0);

        // T5 overflow saturation: 20 pulses on a, no ack
        for (int n = 0; n < 20; n++) begin
            exp_cnt = (n > 15) ? 15 : n;
            bus.i_a = 1'b1;
            cyc($sformatf("t5_rise_%0d", n), (n == 0) ? S_I : S_A, (n != 0), 2'd0,
                4'b0001, 4'(exp_cnt));
            bus.i_a = 1'b0;
            cyc($sformatf("t5_fall_%0d", n), S_A, 1'b1, 2'd0, 4'b0001, 4'(exp_cnt));
        end

        // Reset while a request is presented
        i_rst = 1'b1;
        cyc("t5_midreset", S_I, 1'b0, 2'd0, 4'b0000, 4'd0);
        i_rst = 1'b0;
        cyc("t5_after_reset", S_I, 1'b0, 2'd0, 4'b0000, 4'd0);

        // T6 collision: new edge on a in the ack cycle for id 0
        bus.i_a = 1'b1;
        cyc("t6_pend", S_I, 1'b0, 2'd0, 4'b0001, 4'd0);
        bus.i_a = 1'b0;
        cyc("t6_irq", S_A, 1'b1, 2'd0, 4'b0001, 4'd0);
        bus.i_a = 1'b1;
        cyc("t6_one_ovf", S_A, 1'b1, 2'd0, 4'b0001, 4'd1);
        bus.i_a = 1'b0;
        cyc("t6_hold", S_A, 1'b1, 2'd0, 4'b0001, 4'd1);
        bus.i_a = 1'b1; bus.i_ack = 1'b1;
        cyc("t6_collision", S_G, 1'b0, 2'd0, 4'b0001, 4'd1);
        bus.i_a = 1'b0; bus.i_ack = 1'b0;
        cyc("t6_idle", S_I, 1'b0, 2'd0, 4'b0001, 4'd1);
        cyc("t6_rearm", S_A, 1'b1, 2'd0, 4'b0001, 4'd1);

        // Reset with o_irq=1; c held high across release counts as an edge
        i_rst = 1'b1; bus.i_c = 1'b1;
        cyc("t6_reset", S_I, 1'b0, 2'd0, 4'b0000, 4'd0);
        i_rst = 1'b0;
        cyc("t6_release_edge", S_I, 1'b0, 2'd0, 4'b0100, 4'd0);
        cyc("t6_release_irq", S_A, 1'b1, 2'd2, 4'b0100, 4'd0);
        bus.i_c = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
